// File: rtl/pixel_map_rot.sv
`default_nettype none
// ============================================================================
// Module      : pixel_map_rot
// Description : Raster-order frame-buffer read address generator with
//               rotation about the display centre. Walks every display
//               pixel (col,row), rotates it by signed Q(FRAC) sin/cos
//               coefficients and pushes {sof, valid, address} through a
//               3-stage pipeline into a show-ahead FIFO that the memory
//               controller drains.
// Ports       : CLK       - clock
//               RESET_N   - asynchronous active-low reset
//               iSIN/iCOS - signed rotation coefficients, latched at (0,0)
//               iREAD     - pop the head FIFO entry
//               oADDRESS  - head entry {valid, address}
//               oREADY_N  - FIFO empty
//               oSOF      - head entry is pixel (0,0)
// Options     : define PIXEL_MAP_VFLIP_EN for a vertically flipped buffer
// Revision    : 1.0 - initial release
// ============================================================================
module pixel_map_rot #(
    parameter int H_RES      = 800,
    parameter int V_RES      = 480,
    parameter int COEF_W     = 10,
    parameter int FRAC       = 8,
    parameter int ADDR_W     = 19,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                     CLK,
    input  logic                     RESET_N,
    input  logic signed [COEF_W-1:0] iSIN,
    input  logic signed [COEF_W-1:0] iCOS,
    input  logic                     iREAD,
    output logic [ADDR_W:0]          oADDRESS,
    output logic                     oREADY_N,
    output logic                     oSOF
);

    localparam int c_CW    = (H_RES > 1) ? $clog2(H_RES) : 1;
    localparam int c_RW    = (V_RES > 1) ? $clog2(V_RES) : 1;
    localparam int c_DW    = ((c_CW > c_RW) ? c_CW : c_RW) + 2;  // signed offsets
    localparam int c_PW    = c_DW + COEF_W;                      // full products
    localparam int c_SW    = c_PW + 1;                           // product sums
    localparam int c_AW    = c_SW + ADDR_W;                      // address maths
    localparam int c_PTR_W = $clog2(FIFO_DEPTH);
    localparam int c_CNT_W = c_PTR_W + 1;
    localparam int c_E_W   = ADDR_W + 2;                         // {sof, valid, addr}

    // ---------------- Stage 0: raster counters and issue control ----------
    logic [c_CW-1:0]          r_col;
    logic [c_RW-1:0]          r_row;
    logic [c_CNT_W-1:0]       r_count;
    logic                     r_v1, r_v2, r_v3;
    logic [c_CNT_W-1:0]       w_inflight;
    logic                     w_en;
    logic                     w_first;
    logic signed [COEF_W-1:0] r_sin, r_cos;
    logic signed [COEF_W-1:0] w_sin, w_cos;

    assign w_inflight = c_CNT_W'(r_v1) + c_CNT_W'(r_v2) + c_CNT_W'(r_v3);
    // Reserve FIFO space for everything already in the pipeline so the
    // pipeline can advance unconditionally without ever overflowing.
    assign w_en    = (r_count + w_inflight) < c_CNT_W'(FIFO_DEPTH);
    assign w_first = w_en && (r_col == '0) && (r_row == '0);
    // Pixel (0,0) already uses the freshly sampled coefficients.
    assign w_sin   = w_first ? iSIN : r_sin;
    assign w_cos   = w_first ? iCOS : r_cos;

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_col <= '0;
            r_row <= '0;
            r_sin <= '0;
            r_cos <= COEF_W'(1 << FRAC);
        end else begin
            if (w_first) begin
                r_sin <= iSIN;
                r_cos <= iCOS;
            end
            if (w_en) begin
                if (r_col == c_CW'(H_RES - 1)) begin
                    r_col <= '0;
                    r_row <= (r_row == c_RW'(V_RES - 1)) ? '0 : r_row + c_RW'(1);
                end else begin
                    r_col <= r_col + c_CW'(1);
                end
            end
        end
    end

    // ---------------- Stage 1: centre offsets and products ----------------
    logic signed [c_DW-1:0] w_dx, w_dy;
    logic signed [c_PW-1:0] r_xc, r_ys, r_xs_p, r_yc;
    logic                   r_sof1;

    assign w_dx = c_DW'(r_col) - c_DW'(H_RES / 2);
    assign w_dy = c_DW'(r_row) - c_DW'(V_RES / 2);

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_v1   <= 1'b0;
            r_sof1 <= 1'b0;
            r_xc   <= '0;
            r_ys   <= '0;
            r_xs_p <= '0;
            r_yc   <= '0;
        end else begin
            r_v1   <= w_en;
            r_sof1 <= w_first;
            r_xc   <= c_PW'(w_dx) * c_PW'(w_cos);
            r_ys   <= c_PW'(w_dy) * c_PW'(w_sin);
            r_xs_p <= c_PW'(w_dx) * c_PW'(w_sin);
            r_yc   <= c_PW'(w_dy) * c_PW'(w_cos);
        end
    end

    // ---------------- Stage 2: source coordinates -------------------------
    logic signed [c_SW-1:0] w_xn, w_yn;
    logic signed [c_SW-1:0] r_xs, r_ysrc;
    logic                   r_sof2;

    assign w_xn = c_SW'(r_xc) - c_SW'(r_ys);
    assign w_yn = c_SW'(r_xs_p) + c_SW'(r_yc);

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_v2   <= 1'b0;
            r_sof2 <= 1'b0;
            r_xs   <= '0;
            r_ysrc <= '0;
        end else begin
            r_v2   <= r_v1;
            r_sof2 <= r_sof1;
            // Arithmetic shift floors toward minus infinity.
            r_xs   <= (w_xn >>> FRAC) + c_SW'(H_RES / 2);
            r_ysrc <= (w_yn >>> FRAC) + c_SW'(V_RES / 2);
        end
    end

    // ---------------- Stage 3: bounds check and address -------------------
    logic                   w_valid;
    logic signed [c_SW-1:0] w_row_term;
    logic signed [c_AW-1:0] w_addr_full;
    logic [c_E_W-1:0]       r_e3;

    assign w_valid = !r_xs[c_SW-1]   && (r_xs   < c_SW'(H_RES)) &&
                     !r_ysrc[c_SW-1] && (r_ysrc < c_SW'(V_RES));

`ifdef PIXEL_MAP_VFLIP_EN
    assign w_row_term = c_SW'(V_RES - 1) - r_ysrc;
`else
    assign w_row_term = r_ysrc;
`endif

    assign w_addr_full = c_AW'(w_row_term) * c_AW'(H_RES) + c_AW'(r_xs);

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_v3 <= 1'b0;
            r_e3 <= '0;
        end else begin
            r_v3 <= r_v2;
            r_e3 <= {r_sof2, w_valid, w_valid ? w_addr_full[ADDR_W-1:0] : {ADDR_W{1'b0}}};
        end
    end

    // ---------------- Show-ahead FIFO -------------------------------------
    logic [c_E_W-1:0]   r_mem [FIFO_DEPTH];
    logic [c_PTR_W-1:0] r_wp, r_rp;
    logic               w_rd;
    logic [c_E_W-1:0]   w_head;

    assign w_rd = iREAD && (r_count != '0);

    // Storage needs no reset: the head is masked while the FIFO is empty.
    always_ff @(posedge CLK) begin
        if (r_v3) begin
            r_mem[r_wp] <= r_e3;
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_wp    <= '0;
            r_rp    <= '0;
            r_count <= '0;
        end else begin
            if (r_v3) begin
                r_wp <= r_wp + c_PTR_W'(1);
            end
            if (w_rd) begin
                r_rp <= r_rp + c_PTR_W'(1);
            end
            case ({r_v3, w_rd})
                2'b10:   r_count <= r_count + c_CNT_W'(1);
                2'b01:   r_count <= r_count - c_CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign w_head   = (r_count != '0) ? r_mem[r_rp] : '0;
    assign oADDRESS = w_head[ADDR_W:0];
    assign oSOF     = w_head[ADDR_W+1];
    assign oREADY_N = (r_count == '0);

endmodule
`default_nettype wire

// File: tb/tb_pixel_map_rot.sv
`default_nettype none
// ============================================================================
// Module      : tb_pixel_map_rot
// Description : Self-checking bench for pixel_map_rot on a reduced 40x24
//               display. A behavioural model computes every expected FIFO
//               entry from the rotation equations with integer arithmetic.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pixel_map_rot;

    localparam int H    = 40;
    localparam int V    = 24;
    localparam int CW   = 10;
    localparam int FR   = 8;
    localparam int AW   = 10;
    localparam int FD   = 16;
    localparam int NPIX = H * V;

    logic                 CLK = 1'b0;
    logic                 RESET_N = 1'b0;
    logic signed [CW-1:0] iSIN = '0;
    logic signed [CW-1:0] iCOS = CW'(256);
    logic                 iREAD = 1'b0;
    logic [AW:0]          oADDRESS;
    logic                 oREADY_N;
    logic                 oSOF;

    int g_cmp = 0;
    int g_err = 0;
    int g_frame = 0;
    int g_pix = 0;
    int mcos [0:7];
    int msin [0:7];

    pixel_map_rot #(
        .H_RES(H), .V_RES(V), .COEF_W(CW), .FRAC(FR), .ADDR_W(AW), .FIFO_DEPTH(FD)
    ) dut (
        .CLK(CLK), .RESET_N(RESET_N), .iSIN(iSIN), .iCOS(iCOS), .iREAD(iREAD),
        .oADDRESS(oADDRESS), .oREADY_N(oREADY_N), .oSOF(oSOF)
    );

    always #5 CLK = ~CLK;

    // floor(x / 2^FR) written as a true floor division
    function automatic int fdiv(input int x);
        int d, q;
        d = 1 << FR;
        q = x / d;
        if ((x < 0) && (q * d != x)) q = q - 1;
        return q;
    endfunction

    // expected {sof, valid, addr} for a display pixel and coefficient pair
    function automatic logic [AW+1:0] model(input int col, input int row,
                                            input int c, input int s);
        int dx, dy, xs, ys, rt, addr;
        logic vld;
        logic [AW+1:0] e;
        dx  = col - H / 2;
        dy  = row - V / 2;
        xs  = fdiv(dx * c - dy * s) + H / 2;
        ys  = fdiv(dx * s + dy * c) + V / 2;
        vld = (xs >= 0) && (xs < H) && (ys >= 0) && (ys < V);
`ifdef PIXEL_MAP_VFLIP_EN
        rt  = V - 1 - ys;
`else
        rt  = ys;
`endif
        addr = vld ? rt * H + xs : 0;
        e[AW-1:0] = addr[AW-1:0];
        e[AW]     = vld;
        e[AW+1]   = (col == 0) && (row == 0);
        return e;
    endfunction

    // Pop n entries (every cycle, or on random cycles) and check each head.
    task automatic drain(input string nm, input int n, input bit rnd);
        int left, budget;
        logic [AW+1:0] exp, got;
        left   = n;
        budget = n * 6 + 200;
        while ((left > 0) && (budget > 0)) begin
            @(negedge CLK);
            if (!oREADY_N && (!rnd || ($urandom_range(0, 1) == 1))) begin
                exp = model(g_pix % H, g_pix / H, mcos[g_frame], msin[g_frame]);
                got = {oSOF, oADDRESS};
                g_cmp++;
                if (got !== exp) begin
                    g_err++;
                    $display("FAIL %s: frame %0d pixel %0d got {sof,valid,addr}=%h expected %h",
                             nm, g_frame, g_pix, got, exp);
                end
                g_pix++;
                if (g_pix == NPIX) begin
                    g_pix = 0;
                    if (g_frame < 7) g_frame++;
                end
                iREAD = 1'b1;
                left--;
            end else begin
                // a read request while empty must be ignored
                iREAD = (rnd && oREADY_N) ? 1'($urandom_range(0, 1)) : 1'b0;
            end
            budget--;
        end
        @(negedge CLK);
        iREAD = 1'b0;
        if (left > 0) begin
            g_cmp++;
            g_err++;
            $display("FAIL %s: timeout with %0d pops outstanding, expected 0", nm, left);
        end
    endtask

    // Assert reset, check cleared outputs, release with identity coefficients
    // and check the first entry lands exactly 4 cycles after release.
    task automatic apply_reset(input string nm);
        @(negedge CLK);
        RESET_N = 1'b0;
        iREAD   = 1'b0;
        #1;
        g_cmp += 3;
        if (oREADY_N !== 1'b1) begin
            g_err++; $display("FAIL %s_ready_n: got %b expected 1", nm, oREADY_N);
        end
        if (oADDRESS !== '0) begin
            g_err++; $display("FAIL %s_address: got %h expected 0", nm, oADDRESS);
        end
        if (oSOF !== 1'b0) begin
            g_err++; $display("FAIL %s_sof: got %b expected 0", nm, oSOF);
        end
        iCOS = CW'(256);
        iSIN = '0;
        mcos[0] = 256;
        msin[0] = 0;
        g_frame = 0;
        g_pix   = 0;
        repeat (3) @(negedge CLK);
        RESET_N = 1'b1;
        repeat (3) @(posedge CLK);
        #1;
        g_cmp++;
        if (oREADY_N !== 1'b1) begin
            g_err++; $display("FAIL %s_early: got ready_n=%b expected 1 after 3 cycles", nm, oREADY_N);
        end
        @(posedge CLK);
        #1;
        g_cmp++;
        if (oREADY_N !== 1'b0) begin
            g_err++; $display("FAIL %s_latency: got ready_n=%b expected 0 after 4 cycles", nm, oREADY_N);
        end
    endtask

    task automatic test_reset();
        apply_reset("reset");
    endtask

    task automatic test_identity();
        drain("identity", 150, 1'b0);
    endtask

    task automatic test_backpressure();
        iREAD = 1'b0;
        repeat (200) @(posedge CLK);
        @(negedge CLK);
        g_cmp++;
        if (oREADY_N !== 1'b0) begin
            g_err++; $display("FAIL backpressure_ready_n: got %b expected 0", oREADY_N);
        end
        drain("backpressure_resume", 100, 1'b0);
    endtask

    task automatic test_random_read();
        drain("random_read", 200, 1'b1);
    endtask

    task automatic test_coef_switch();
        int c, s;
        // mid frame 0: switch to 90 degrees, which must only apply to frame 1
        iCOS = '0;
        iSIN = CW'(256);
        mcos[g_frame + 1] = 0;
        msin[g_frame + 1] = 256;
        drain("coef_switch_90", (NPIX - g_pix) + NPIX / 2, 1'b0);
        // mid frame 1: random coefficients for frame 2
        c = int'($urandom_range(0, 512)) - 256;
        s = int'($urandom_range(0, 512)) - 256;
        iCOS = CW'(c);
        iSIN = CW'(s);
        mcos[g_frame + 1] = c;
        msin[g_frame + 1] = s;
        drain("coef_switch_rand", (NPIX - g_pix) + 300, 1'b1);
    endtask

    task automatic test_reset_mid();
        iREAD = 1'b0;
        repeat (30) @(posedge CLK);
        apply_reset("reset_mid");
        drain("after_reset", 100, 1'b0);
    endtask

    initial begin
        mcos[0] = 256;
        msin[0] = 0;
        test_reset();
        test_identity();
        test_backpressure();
        test_random_read();
        test_coef_switch();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", g_cmp, g_err);
        $finish;
    end

endmodule
`default_nettype wire
